aes_key_schedule_seq: RTL and testbench
=======================================

Name: aes_key_schedule_seq

Overview:
Sequential AES key-expansion engine generalised over key size (AES-128/192/256). It loads a cipher key, then generates one 32-bit schedule word per clock into an internal round-key buffer. It exposes the round keys through an indexed read port for the round datapath. It supersedes the single-round combinational expansion: it iterates over all rounds, tracks Rcon internally, handles the Nk=8 extra SubWord step, and uses a start/busy/done handshake.

Parameters:
KEY_WIDTH, 128, cipher key width; legal values 128, 192, 256 (elaboration error otherwise); Nk = KEY_WIDTH/32, Nr = Nk+6, Nw = 4*(Nr+1).
IDX_WIDTH, 4, width of the round-key index port (covers 0..14).

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  load key_i and begin expansion; honoured only when busy_o=0
key_i  in  KEY_WIDTH  cipher key, MSB = first key byte (FIPS-197 order)
busy_o  out  1  expansion in progress
done_o  out  1  schedule complete and valid (level)
rk_idx_i  in  IDX_WIDTH  round-key index 0..Nr
rk_o  out  128  round key rk_idx_i = words w[4r]..w[4r+3], w[4r] in MSBs

Behaviour:
- Reset (async assert, sync deassert via the external reset tree): state=IDLE, busy_o=0, done_o=0, word buffer cleared to 0, word counter=0, rcon=0x01. Reset mid-expansion aborts the expansion. The buffer is cleared, and done_o stays 0 until a new complete run finishes.
- FSM states: IDLE, EXPAND.
- IDLE: on start_i=1, the edge writes key_i into w[0..Nk-1], sets counter i=Nk, rcon=0x01, kmod=0, busy_o=1, done_o=0, and goes to EXPAND. With start_i=0, IDLE holds its state.
- EXPAND, per cycle: temp=w[i-1].
  - If kmod==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon <= xtime(rcon) (0x80 -> 0x1B).
  - Else if Nk==8 and kmod==4: temp = SubWord(temp).
  - w[i] <= w[i-Nk] ^ temp; i <= i+1; kmod wraps at Nk-1 -> 0.
- Last word: the edge that writes w[Nw-1] also sets done_o=1, clears busy_o and returns to IDLE.
  - busy_o is high for exactly Nw-Nk cycles: 40 for AES-128, 46 for AES-192, 52 for AES-256.
- start_i while busy_o=1 is ignored and does not restart the expansion.
- start_i in IDLE with done_o=1 drops done_o on that edge and restarts the expansion. Previous buffer contents are overwritten progressively.
- rk_o is a combinational read of the buffer. It returns 128'h0 when rk_idx_i > Nr. While busy_o=1 the value is defined but not guaranteed valid; consumers qualify rk_o with done_o.
- Word buffer: Nw x 32 flops. No RAM inference is required.
- Rcon used on the final kmod==0 step: 0x36 (AES-128), 0x80 (AES-192), 0x40 (AES-256). No rcon overflow is reachable.

Decomposition:
- Shared package aes_pkg:
  - AES word/state typedefs
  - functions nk_of(KEY_WIDTH), nr_of(KEY_WIDTH), xtime(byte)
  - constant RCON_INIT = 8'h01
- One natural sub-module: aes_sbox, combinational 8-bit S-box. Four instances form SubWord. The same module is reused by SubBytes.
- The FSM, counters and buffer stay in this module.

Test Plan:
1. KEY_WIDTH=128:
   - Stimulus: start with key 2b7e151628aed2a6abf7158809cf4f3c.
   - Required: busy_o high for 40 cycles, then done_o=1.
   - Required reads: rk_idx=0 -> the key itself; rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=11 -> 0.
2. KEY_WIDTH=192:
   - Stimulus: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
   - Required: busy_o high for 46 cycles; rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
3. KEY_WIDTH=256:
   - Stimulus: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
   - Required: busy_o high for 52 cycles; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e. This checks the kmod==4 SubWord path.
4. Ignored start:
   - Stimulus: pulse start_i with a different key during cycle 10 of an AES-128 expansion.
   - Required: no restart; final keys match scenario 1; busy_o length is still 40.
5. Reset mid-operation:
   - Stimulus: assert rst_n_i=0 asynchronously mid-clock at cycle 20 of an expansion.
   - Required: busy_o, done_o and rk_o go to 0 immediately.
   - Then release reset and start again. Required: correct scenario-1 results after 40 cycles.
6. Back-to-back runs:
   - Stimulus: start with key all-zero immediately after done_o (AES-128).
   - Required: done_o drops on the start edge. After 40 cycles, rk_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, key-size helpers and GF(2^8) xtime
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic {
    KS_IDLE,
    KS_EXPAND
  } ks_state_e;

  localparam aes_byte_t RCON_INIT = 8'h01;

  function automatic int nk_of(input int key_width);
    return key_width / 32;
  endfunction

  function automatic int nr_of(input int key_width);
    return (key_width / 32) + 6;
  endfunction

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box: GF(2^8) inverse followed by the affine map
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] sub_byte
);

  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  aes_byte_t inv;
  aes_byte_t sq;

  // x^254 is the multiplicative inverse (and maps 0 to 0): product of x^2 .. x^128
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign sub_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - sequential AES-128/192/256 key expansion, one word per clock
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH = 128,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [IDX_WIDTH-1:0] rk_idx_i,
  output logic [127:0]         rk_o
);

  localparam int NK = nk_of(KEY_WIDTH);
  localparam int NR = nr_of(KEY_WIDTH);
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0]           NK_CNT    = 6'(NK);
  localparam logic [5:0]           LAST_CNT  = 6'(NW - 1);
  localparam logic [2:0]           KMOD_LAST = 3'(NK - 1);
  localparam logic [IDX_WIDTH-1:0] NR_IDX    = IDX_WIDTH'(NR);

  if (KEY_WIDTH != 128 && KEY_WIDTH != 192 && KEY_WIDTH != 256) begin : g_bad_key_width
    $error("aes_key_schedule_seq: KEY_WIDTH must be 128, 192 or 256");
  end

  ks_state_e state_q, state_d;
  aes_word_t w [NW];
  logic [5:0] cnt_q;
  logic [2:0] kmod_q;
  aes_byte_t  rcon_q;

  logic load, step, last;

  aes_word_t key_w [NK];
  for (genvar j = 0; j < NK; j++) begin : g_key_words
    assign key_w[j] = key_i[KEY_WIDTH-1-32*j -: 32];
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last    = 1'b1;
          state_d = KS_IDLE;
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= KS_IDLE;
    else          state_q <= state_d;
  end

  // Next-word datapath: RotWord only on the kmod==0 step, SubWord shared by both substitution cases
  aes_word_t w_prev, w_back, sub_in, sub_out, temp, w_new;

  assign w_prev = w[cnt_q - 6'd1];
  assign w_back = w[cnt_q - NK_CNT];
  assign sub_in = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .sub_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = w_prev;
    if (kmod_q == 3'd0)                temp = sub_out ^ {rcon_q, 24'h000000};
    else if (NK == 8 && kmod_q == 3'd4) temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < NW; j++) w[j] <= '0;
      cnt_q  <= '0;
      kmod_q <= '0;
      rcon_q <= RCON_INIT;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      if (load) begin
        for (int j = 0; j < NK; j++) w[j] <= key_w[j];
        cnt_q  <= NK_CNT;
        kmod_q <= '0;
        rcon_q <= RCON_INIT;
        busy_o <= 1'b1;
        done_o <= 1'b0;
      end
      if (step) begin
        for (int j = 0; j < NW; j++) begin
          if (cnt_q == 6'(j)) w[j] <= w_new;
        end
        cnt_q  <= cnt_q + 6'd1;
        kmod_q <= (kmod_q == KMOD_LAST) ? 3'd0 : kmod_q + 3'd1;
        if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (last) begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

  logic [5:0] base;
  assign base = 6'(rk_idx_i) << 2;

  always_comb begin
    rk_o = '0;
    if (rk_idx_i <= NR_IDX) rk_o = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - directed vector bench for the sequential AES key schedule
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
  logic [127:0] key128 = '0;
  logic [191:0] key192 = '0;
  logic [255:0] key256 = '0;
  logic [3:0]   idx128 = '0, idx192 = '0, idx256 = '0;
  logic         busy128, busy192, busy256, done128, done192, done256;
  logic [127:0] rk128, rk192, rk256;

  aes_key_schedule_seq #(.KEY_WIDTH(128), .IDX_WIDTH(4)) d128 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start128), .key_i(key128),
    .busy_o(busy128), .done_o(done128), .rk_idx_i(idx128), .rk_o(rk128));
  aes_key_schedule_seq #(.KEY_WIDTH(192), .IDX_WIDTH(4)) d192 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start192), .key_i(key192),
    .busy_o(busy192), .done_o(done192), .rk_idx_i(idx192), .rk_o(rk192));
  aes_key_schedule_seq #(.KEY_WIDTH(256), .IDX_WIDTH(4)) d256 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start256), .key_i(key256),
    .busy_o(busy256), .done_o(done256), .rk_idx_i(idx256), .rk_o(rk256));

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           sel;
    logic [3:0]   idx;
    logic [127:0] exp;
    string        name;
  } rk_vec_t;

  rk_vec_t vecs [12];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] read_rk(input int sel);
    case (sel)
      128:     return rk128;
      192:     return rk192;
      default: return rk256;
    endcase
  endfunction

  task automatic read_check(input int sel, input logic [3:0] idx, input logic [127:0] exp, input string name);
    @(negedge clk);
    case (sel)
      128:     idx128 = idx;
      192:     idx192 = idx;
      default: idx256 = idx;
    endcase
    #1;
    check(name, read_rk(sel), exp);
  endtask

  // Starts AES-128, counts busy cycles; optionally pulses start with another key at busy cycle pulse_at
  task automatic run128(input logic [127:0] key, input int pulse_at, output int cycles);
    @(negedge clk);
    key128   = key;
    start128 = 1'b1;
    @(posedge clk);
    #1;
    start128 = 1'b0;
    check("start_done_drop", {127'd0, done128}, 128'd0);
    check("start_busy_rise", {127'd0, busy128}, 128'd1);
    cycles = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      start128 = 1'b0;
      if (!busy128) break;
      cycles++;
      if (cycles == pulse_at) begin
        key128   = ~key;
        start128 = 1'b1;
      end
    end
    check("run_done", {127'd0, done128}, 128'd1);
  endtask

  int c128, c192, c256;

  initial begin
    vecs[0]  = '{128, 4'd0,  K128,                                   "r128_k0"};
    vecs[1]  = '{128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605,  "r128_k1"};
    vecs[2]  = '{128, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f,  "r128_k2"};
    vecs[3]  = '{128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,  "r128_k10"};
    vecs[4]  = '{128, 4'd11, 128'h0,                                 "r128_k11"};
    vecs[5]  = '{192, 4'd0,  K192[191:64],                           "r192_k0"};
    vecs[6]  = '{192, 4'd12, 128'he98ba06f448c773c8ecc720401002202,  "r192_k12"};
    vecs[7]  = '{192, 4'd13, 128'h0,                                 "r192_k13"};
    vecs[8]  = '{256, 4'd0,  K256[255:128],                          "r256_k0"};
    vecs[9]  = '{256, 4'd1,  K256[127:0],                            "r256_k1"};
    vecs[10] = '{256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e,  "r256_k14"};
    vecs[11] = '{256, 4'd15, 128'h0,                                 "r256_k15"};

    repeat (3) @(negedge clk);
    check("reset_busy", {125'd0, busy128, busy192, busy256}, 128'd0);
    check("reset_done", {125'd0, done128, done192, done256}, 128'd0);
    check("reset_rk128", rk128, 128'd0);
    rst_n = 1'b1;

    // All three key sizes expand concurrently
    @(negedge clk);
    key128 = K128; key192 = K192; key256 = K256;
    start128 = 1'b1; start192 = 1'b1; start256 = 1'b1;
    @(negedge clk);
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    c128 = 1; c192 = 1; c256 = 1;
    for (int t = 0; t < 100 && (busy128 || busy192 || busy256); t++) begin
      @(negedge clk);
      if (busy128) c128++;
      if (busy192) c192++;
      if (busy256) c256++;
    end
    check("busy_len_128", 128'(c128), 128'd40);
    check("busy_len_192", 128'(c192), 128'd46);
    check("busy_len_256", 128'(c256), 128'd52);
    check("done_all", {125'd0, done128, done192, done256}, 128'd7);

    for (int v = 0; v < 12; v++) read_check(vecs[v].sel, vecs[v].idx, vecs[v].exp, vecs[v].name);

    // Start pulse during busy must be ignored
    run128(K128, 10, c128);
    check("ign_busy_len", 128'(c128), 128'd40);
    read_check(128, 4'd1,  vecs[1].exp, "ign_k1");
    read_check(128, 4'd10, vecs[3].exp, "ign_k10");

    // Asynchronous reset in the middle of a clock period, at busy cycle 20
    @(negedge clk);
    key128 = K128; start128 = 1'b1;
    @(negedge clk);
    start128 = 1'b0;
    idx128 = 4'd0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {127'd0, busy128}, 128'd0);
    check("rst_mid_done", {127'd0, done128}, 128'd0);
    check("rst_mid_rk0", rk128, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run128(K128, 0, c128);
    check("rst_rerun_len", 128'(c128), 128'd40);
    read_check(128, 4'd10, vecs[3].exp, "rst_rerun_k10");

    // Back-to-back: new start straight after done
    run128(128'h0, 0, c128);
    check("b2b_len", 128'(c128), 128'd40);
    read_check(128, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "b2b_k10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
